// File: rtl/assert_event_logger.sv
// Collects per-cycle checker strobes: gated pass/fail counters, first-failure capture,
// and a timestamped failure FIFO fed through a per-checker pending stage.
module assert_event_logger #(
  parameter int NCHK  = 4,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_global,
  input  logic [NCHK-1:0]       chk_mask,
  input  logic                  disable_iff,
  input  logic                  clr,
  input  logic [NCHK-1:0]       chk_valid,
  input  logic [NCHK-1:0]       chk_pass,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [3:0]            rec_id,
  output logic [TS_W-1:0]       rec_ts,
  output logic [NCHK*CNT_W-1:0] pass_cnt,
  output logic [NCHK*CNT_W-1:0] fail_cnt,
  output logic                  first_fail_valid,
  output logic [3:0]            first_fail_id,
  output logic [TS_W-1:0]       first_fail_ts,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]  ts_q;
  logic [NCHK-1:0]  qual, q_pass, q_fail;
  logic [NCHK-1:0]  pend_q, pend_d, grant_oh, drop_vec;
  logic [TS_W-1:0]  pend_ts_q [NCHK];
  logic [TS_W-1:0]  pend_ts_d [NCHK];
  logic             grant_any, wr_fire, rd_fire, fifo_empty, fifo_full;
  logic [3:0]       grant_idx;
  logic [TS_W-1:0]  grant_ts;
  logic [CNT_W-1:0] pass_q [NCHK];
  logic [CNT_W-1:0] pass_d [NCHK];
  logic [CNT_W-1:0] fail_q [NCHK];
  logic [CNT_W-1:0] fail_d [NCHK];
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             ff_valid_q, ff_valid_d;
  logic [3:0]       ff_id_q, ff_id_d;
  logic [TS_W-1:0]  ff_ts_q, ff_ts_d;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [3:0]       mem_id [DEPTH];
  logic [TS_W-1:0]  mem_ts [DEPTH];

  assign qual   = chk_valid & chk_mask & {NCHK{en_global & ~disable_iff}};
  assign q_pass = qual & chk_pass;
  assign q_fail = qual & ~chk_pass;

  // Fixed-priority arbiter: lowest pending index goes to the FIFO first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_any = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_ts  = '0;
    for (int i = 0; i < NCHK; i++) begin
      if (pend_q[i] && !grant_any) begin
        grant_any   = 1'b1;
        grant_oh[i] = 1'b1;
        grant_idx   = 4'(i);
        grant_ts    = pend_ts_q[i];
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire    = rec_ready & ~fifo_empty;
  assign wr_fire    = grant_any & (~fifo_full | rd_fire);

  // A slot drained this cycle may be refilled in the same cycle without a drop.
  always_comb begin
    pend_d    = pend_q & ~(grant_oh & {NCHK{wr_fire}});
    pend_ts_d = pend_ts_q;
    drop_vec  = '0;
    for (int i = 0; i < NCHK; i++) begin
      if (q_fail[i]) begin
        if (pend_d[i]) begin
          drop_vec[i] = 1'b1;
        end else begin
          pend_d[i]    = 1'b1;
          pend_ts_d[i] = ts_q;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCHK; i++) begin
      pass_d[i] = pass_q[i];
      fail_d[i] = fail_q[i];
      if (clr) begin
        pass_d[i] = '0;
        fail_d[i] = '0;
      end else begin
        if (q_pass[i] && pass_q[i] != '1) pass_d[i] = pass_q[i] + CNT_W'(1);
        if (q_fail[i] && fail_q[i] != '1) fail_d[i] = fail_q[i] + CNT_W'(1);
      end
    end
    drop_d     = drop_q;
    ovf_d      = ovf_q;
    ff_valid_d = ff_valid_q;
    ff_id_d    = ff_id_q;
    ff_ts_d    = ff_ts_q;
    if (clr) begin
      drop_d     = '0;
      ovf_d      = 1'b0;
      ff_valid_d = 1'b0;
      ff_id_d    = '0;
      ff_ts_d    = '0;
    end else begin
      for (int i = 0; i < NCHK; i++) begin
        if (drop_vec[i]) begin
          ovf_d = 1'b1;
          if (drop_d != '1) drop_d = drop_d + CNT_W'(1);
        end
      end
      for (int i = NCHK - 1; i >= 0; i--) begin
        if (!ff_valid_q && q_fail[i]) begin
          ff_valid_d = 1'b1;
          ff_id_d    = 4'(i);
          ff_ts_d    = ts_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ts_q       <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
      ff_valid_q <= 1'b0;
      ff_id_q    <= '0;
      ff_ts_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < NCHK; i++) begin
        pend_ts_q[i] <= '0;
        pass_q[i]    <= '0;
        fail_q[i]    <= '0;
      end
    end else begin
      ts_q       <= ts_q + TS_W'(1);
      pend_q     <= pend_d;
      pend_ts_q  <= pend_ts_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
      ff_valid_q <= ff_valid_d;
      ff_id_q    <= ff_id_d;
      ff_ts_q    <= ff_ts_d;
      if (wr_fire) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_id[wr_ptr_q[AW-1:0]] <= grant_idx;
      mem_ts[wr_ptr_q[AW-1:0]] <= grant_ts;
    end
  end

  assign rec_valid = ~fifo_empty;
  assign rec_id    = fifo_empty ? '0 : mem_id[rd_ptr_q[AW-1:0]];
  assign rec_ts    = fifo_empty ? '0 : mem_ts[rd_ptr_q[AW-1:0]];

  for (genvar g = 0; g < NCHK; g++) begin : g_pack
    assign pass_cnt[g*CNT_W +: CNT_W] = pass_q[g];
    assign fail_cnt[g*CNT_W +: CNT_W] = fail_q[g];
  end

  assign first_fail_valid = ff_valid_q;
  assign first_fail_id    = ff_id_q;
  assign first_fail_ts    = ff_ts_q;
  assign drop_cnt         = drop_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_assert_event_logger.sv
// Scoreboard bench: directed failure streams push expected records; a negedge
// monitor pops and compares each record the DUT hands over.
module tb_assert_event_logger;
  localparam int NCHK = 4, CNT_W = 16, TS_W = 32, DEPTH = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic en_global, disable_iff, clr, rec_ready;
  logic [NCHK-1:0] chk_mask, chk_valid, chk_pass;

  logic rec_valid, first_fail_valid, overflow;
  logic [3:0] rec_id, first_fail_id;
  logic [TS_W-1:0] rec_ts, first_fail_ts;
  logic [NCHK*CNT_W-1:0] pass_cnt, fail_cnt;
  logic [CNT_W-1:0] drop_cnt;

  logic s_rec_valid, s_ff_valid, s_overflow;
  logic [3:0] s_rec_id, s_ff_id;
  logic [TS_W-1:0] s_rec_ts, s_ff_ts;
  logic [NCHK*4-1:0] s_pass_cnt, s_fail_cnt;
  logic [3:0] s_drop_cnt;

  always #5 clk = ~clk;

  assert_event_logger #(.NCHK(NCHK), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en_global(en_global), .chk_mask(chk_mask),
    .disable_iff(disable_iff), .clr(clr), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id), .rec_ts(rec_ts),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_valid(first_fail_valid),
    .first_fail_id(first_fail_id), .first_fail_ts(first_fail_ts),
    .drop_cnt(drop_cnt), .overflow(overflow));

  // Narrow-counter instance sharing the same stimulus, used for saturation and clr.
  assert_event_logger #(.NCHK(NCHK), .CNT_W(4), .TS_W(TS_W), .DEPTH(DEPTH)) dut_s (
    .clk(clk), .rst(rst), .en_global(en_global), .chk_mask(chk_mask),
    .disable_iff(disable_iff), .clr(clr), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .rec_valid(s_rec_valid), .rec_ready(rec_ready), .rec_id(s_rec_id), .rec_ts(s_rec_ts),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .first_fail_valid(s_ff_valid),
    .first_fail_id(s_ff_id), .first_fail_ts(s_ff_ts),
    .drop_cnt(s_drop_cnt), .overflow(s_overflow));

  typedef struct packed {
    logic [3:0]      id;
    logic [TS_W-1:0] ts;
  } rec_t;

  rec_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rec_unexpected: got id=%0d ts=%0d expected none", rec_id, rec_ts);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("rec_id", 64'(rec_id), 64'(e.id));
        check("rec_ts", 64'(rec_ts), 64'(e.ts));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chk_valid = '0; chk_pass = '0; en_global = 1'b1; chk_mask = '1;
    disable_iff = 1'b0; clr = 1'b0;
  endtask

  // Leaves the bench in cycle 0 (ts = 0).
  task automatic do_reset();
    idle();
    rec_ready = 1'b1;
    exp_q.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input int id, input int ts_lo, input int ts_hi);
    for (int t = ts_lo; t <= ts_hi; t++) exp_q.push_back({4'(id), TS_W'(t)});
  endtask

  task automatic drain(input string name);
    idle();
    rec_ready = 1'b1;
    for (int k = 0; k < 100 && (exp_q.size() != 0 || rec_valid); k++) tick();
    check({name, "_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_empty"}, 64'(rec_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then ten passes on checker 2.
    do_reset();
    check("rst_rec", {rec_valid, rec_id, rec_ts}, 64'd0);
    check("rst_pass", pass_cnt, 64'd0);
    check("rst_fail", fail_cnt, 64'd0);
    check("rst_ff", {first_fail_valid, first_fail_id, first_fail_ts}, 64'd0);
    check("rst_drop", {overflow, drop_cnt}, 64'd0);
    for (int t = 0; t < 10; t++) begin
      chk_valid = 4'b0100; chk_pass = 4'b0100;
      tick();
    end
    idle();
    check("t1_pass", pass_cnt, {16'd0, 16'd10, 16'd0, 16'd0});
    check("t1_fail", fail_cnt, 64'd0);
    check("t1_rv", 64'(rec_valid), 64'd0);

    // Global enable off for cycles 0-4, checker 0 fails through cycle 7.
    do_reset();
    push(0, 5, 7);
    for (int t = 0; t < 8; t++) begin
      if (t == 6) check("t2_rv_c6", 64'(rec_valid), 64'd0);
      if (t == 7) begin
        check("t2_rv_c7", 64'(rec_valid), 64'd1);
        check("t2_ts_c7", 64'(rec_ts), 64'd5);
      end
      en_global = (t >= 5); chk_valid = 4'b0001; chk_pass = 4'b0000;
      tick();
    end
    idle();
    check("t2_fail0", 64'(fail_cnt[15:0]), 64'd3);
    check("t2_ff", {first_fail_valid, first_fail_id, first_fail_ts}, {1'b1, 4'd0, 32'd5});
    drain("t2");

    // Mask out checker 0, disable_iff in cycle 3, all fail in cycles 3 and 4.
    do_reset();
    push(1, 4, 4); push(2, 4, 4); push(3, 4, 4);
    for (int t = 0; t < 6; t++) begin
      idle();
      chk_mask = 4'b1110;
      if (t == 3 || t == 4) begin
        chk_valid = 4'b1111; chk_pass = 4'b0000; disable_iff = (t == 3);
      end
      tick();
    end
    idle();
    check("t3_fail", fail_cnt, {16'd1, 16'd1, 16'd1, 16'd0});
    check("t3_ff", {first_fail_valid, first_fail_id, first_fail_ts}, {1'b1, 4'd1, 32'd4});
    drain("t3");
    check("t3_drop", {overflow, drop_cnt}, 64'd0);

    // Consumer stalled, checker 1 fails 20 cycles in a row.
    do_reset();
    rec_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      chk_valid = 4'b0010; chk_pass = 4'b0000;
      tick();
    end
    idle();
    check("t4_head", {rec_valid, rec_id, rec_ts}, {1'b1, 4'd1, 32'd0});
    check("t4_ovf", 64'(overflow), 64'd1);
    check("t4_drop", 64'(drop_cnt), 64'd11);
    check("t4_fail1", 64'(fail_cnt[31:16]), 64'd20);
    push(1, 0, 8);
    drain("t4");

    // Full FIFO plus pending entry; read and new failure in the same cycle.
    do_reset();
    push(0, 0, 9);
    rec_ready = 1'b0;
    for (int t = 0; t < 9; t++) begin
      chk_valid = 4'b0001; chk_pass = 4'b0000;
      tick();
    end
    check("t5_head9", 64'(rec_ts), 64'd0);
    rec_ready = 1'b1; chk_valid = 4'b0001; chk_pass = 4'b0000;
    tick();
    idle();
    rec_ready = 1'b0;
    check("t5_drop", {overflow, drop_cnt}, 64'd0);
    check("t5_fail0", 64'(fail_cnt[15:0]), 64'd10);
    check("t5_head10", {rec_valid, rec_ts}, {1'b1, 32'd1});
    tick();
    check("t5_stable", {rec_valid, rec_id, rec_ts}, {1'b1, 4'd0, 32'd1});
    drain("t5");

    // Saturation on the 4-bit instance, then clr with a coincident pass event.
    do_reset();
    rec_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      chk_valid = 4'b0001; chk_pass = 4'b0000;
      tick();
    end
    idle();
    check("t6_sat", 64'(s_fail_cnt[3:0]), 64'd15);
    check("t6_sdrop", {s_overflow, s_drop_cnt}, {1'b1, 4'd11});
    check("t6_sff", 64'(s_ff_valid), 64'd1);
    clr = 1'b1; chk_valid = 4'b1000; chk_pass = 4'b1000;
    tick();
    idle();
    check("t6_clr_cnt", {s_pass_cnt, s_fail_cnt}, 64'd0);
    check("t6_clr_ff", {s_ff_valid, s_ff_id, s_ff_ts}, 64'd0);
    check("t6_clr_drop", {s_overflow, s_drop_cnt}, 64'd0);
    check("t6_clr_main", {overflow, drop_cnt, fail_cnt[15:0]}, 64'd0);
    check("t6_fifo_kept", {rec_valid, rec_id, rec_ts}, {1'b1, 4'd0, 32'd0});
    check("t6_sfifo_kept", {s_rec_valid, s_rec_ts}, {1'b1, 32'd0});
    push(0, 0, 8);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
